// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder: FSM state encoding
// and the chunk-index counter width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk adder still needs a 1-bit index so the register is legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from single-bit full adders;
// also exposes the carry into its top bit for overflow detection.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin processed CHUNK bits per clock,
// with the inter-chunk carry registered, behind valid/ready handshakes.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_serial_adder_if.slave  bus
);

  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N          = WIDTH / SAFE_CHUNK;
  localparam int IW         = idx_width(N);

  if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_bad_params
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t            state, next_state;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              cout_reg, ovf_reg;
  logic [CHUNK-1:0]  a_slice, b_slice, s_slice;
  logic              chunk_cout, chunk_c_msb;
  logic              last_chunk;

  assign a_slice    = a_reg[idx*CHUNK +: CHUNK];
  assign b_slice    = b_reg[idx*CHUNK +: CHUNK];
  assign last_chunk = (idx == IW'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_slice),
    .b     (b_slice),
    .cin   (carry),
    .s     (s_slice),
    .cout  (chunk_cout),
    .c_msb (chunk_c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_chunk) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result registers are only written while running, so they hold through
  // DONE and the following IDLE until the next operation replaces them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx*CHUNK +: CHUNK] <= s_slice;
          carry <= chunk_cout;
          if (last_chunk) begin
            cout_reg <= chunk_cout;
            ovf_reg  <= chunk_c_msb ^ chunk_cout;
          end else if (N > 1) begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Multi-cycle, parametrised successor to the single-bit full_adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, with the inter-chunk carry held in a register.
- Trades latency for area. Sits between an operand producer and a result consumer on valid/ready handshakes.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 gives a bit-serial adder, CHUNK == WIDTH gives a single-cycle pass.

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Definitions:
  - N = WIDTH/CHUNK.
  - Chunk index idx is a counter of width max(1, clog2(N)).
  - Elaboration fails if WIDTH % CHUNK != 0 or CHUNK < 1.
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; idx, carry, operand and result registers are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Reset mid-operation aborts the operation and drops any in-flight result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at a rising edge, capture a, b and cin into the carry register, set idx=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge adds the operand slice [idx*CHUNK +: CHUNK] plus the carry register.
  - It writes that slice of the sum register and updates the carry register.
  - While idx < N-1, idx increments.
  - At idx == N-1, cout is taken from the carry out, ovf from (carry into top bit XOR carry out), and the state goes to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable.
  - On out_ready at a rising edge, go to IDLE and deassert out_valid. sum, cout and ovf keep their last values until the next operation overwrites them.
- Latency:
  - Operands are accepted at edge T; out_valid is high from edge T+N onward.
  - Minimum issue interval is N+2 cycles: one IDLE cycle, N RUN cycles, one DONE cycle with out_ready=1.
- Handshake rules:
  - in_valid outside IDLE is ignored; the producer holds its data.
  - Operands change after acceptance have no effect, because they are registered.
  - out_ready outside DONE has no effect.
  - out_valid never drops without out_ready.
- Widths:
  - Per-chunk sum is CHUNK+1 bits; the MSB is the next carry.
  - sum wraps modulo 2^WIDTH; there is no saturation.
- N == 1: RUN lasts exactly one cycle; the idx counter is unused and is tied to 0.

Decomposition:
- Shared package adder_pkg:
  - FSM state enum typedef (IDLE, RUN, DONE).
  - A function computing the idx width.
- Sub-module chunk_adder, parameter CHUNK:
  - Combinational ripple of CHUNK full_adder instances.
  - Inputs: a, b, cin. Outputs: s[CHUNK], cout, and c_msb (the carry into the top bit, used for ovf).
- The top level holds the FSM, idx counter, carry register, operand registers and result registers.

Test Plan:
- WIDTH=16, CHUNK=4; a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0. out_valid rises exactly 4 edges after the accepting edge.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands. Required: sum, cout, ovf stable; in_ready=0; new operands not captured. After out_ready=1: IDLE, in_ready=1.
- Reset mid-RUN: drop rst_n at idx=2 for one edge. Required next cycle: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. A following operation 0x0005+0x0003 gives sum=0x0008.
- Width/chunk corners: CHUNK=16 (N=1) gives out_valid 1 edge after accept. CHUNK=1 (N=16) gives out_valid 16 edges after accept.
- Random checks: 1000 random a, b, cin per config, compared against a reference model for sum, cout, ovf.
